// File: rtl/fc_argmax_collector_if.sv
// Score-in / result-out bundle of the FC argmax collector.
// The collector uses the slave modport; whoever feeds scores and takes results uses master.
interface fc_argmax_collector_if #(
  parameter int CLS_W = 4
);
  logic             in_vld;
  logic [7:0]       in_score;
  logic             clear;
  logic             res_vld;
  logic             res_rdy;
  logic [CLS_W-1:0] res_class;
  logic [7:0]       res_score;
  logic             ovf_err;

  modport master (
    output in_vld, in_score, clear, res_rdy,
    input  res_vld, res_class, res_score, ovf_err
  );

  modport slave (
    input  in_vld, in_score, clear, res_rdy,
    output res_vld, res_class, res_score, ovf_err
  );
endinterface

// File: rtl/fc_argmax_collector.sv
// Running argmax over NUM_CLASS FC scores per frame; the result is held under valid/ready.
// FC_ARGMAX_SCORES_EN adds the scores_lin output carrying every captured score of the frame.
module fc_argmax_collector #(
  parameter int NUM_CLASS  = 10,
  parameter int CLS_W      = 4,
  parameter int SIGNED_CMP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  fc_argmax_collector_if.slave    bus,
`ifdef FC_ARGMAX_SCORES_EN
  output logic [NUM_CLASS*8-1:0]  scores_lin,
`endif
  output logic                    dbg_state_o
);
  // Handshake: a result is transferred on every rising edge where res_vld && res_rdy;
  // res_vld, res_class and res_score do not change while res_vld is high and res_rdy is low.

  localparam int CNT_W = $clog2(NUM_CLASS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLASS - 1);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       max_q, max_d;
  logic [CLS_W-1:0] idx_q, idx_d;
  logic             ovf_q, ovf_d;
  logic             capture;
  logic             gt;
`ifdef FC_ARGMAX_SCORES_EN
  logic [NUM_CLASS*8-1:0] scores_q, scores_d;
`endif

  always_comb begin
    if (SIGNED_CMP != 0) gt = $signed(bus.in_score) > $signed(max_q);
    else                 gt = bus.in_score > max_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= COLLECT;
      cnt_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      ovf_q    <= 1'b0;
`ifdef FC_ARGMAX_SCORES_EN
      scores_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      max_q    <= max_d;
      idx_q    <= idx_d;
      ovf_q    <= ovf_d;
`ifdef FC_ARGMAX_SCORES_EN
      scores_q <= scores_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    max_d    = max_q;
    idx_d    = idx_q;
    ovf_d    = ovf_q;
    capture  = 1'b0;
`ifdef FC_ARGMAX_SCORES_EN
    scores_d = scores_q;
`endif

    if (bus.clear) begin
      state_d  = COLLECT;
      cnt_d    = '0;
      ovf_d    = 1'b0;
`ifdef FC_ARGMAX_SCORES_EN
      scores_d = '0;
`endif
    end else begin
      unique case (state_q)
        COLLECT: capture = bus.in_vld;
        HOLD: begin
          if (bus.res_rdy) begin
            state_d = COLLECT;
            // cnt is already 0 here, so a same-cycle score opens the next frame
            capture = bus.in_vld;
          end else if (bus.in_vld) begin
            ovf_d = 1'b1;
          end
        end
        default: state_d = COLLECT;
      endcase

      if (capture) begin
        if (cnt_q == '0) begin
          max_d = bus.in_score;
          idx_d = '0;
        end else if (gt) begin
          max_d = bus.in_score;
          idx_d = CLS_W'(cnt_q);
        end
`ifdef FC_ARGMAX_SCORES_EN
        scores_d[int'(cnt_q)*8 +: 8] = bus.in_score;
`endif
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  assign bus.res_vld   = (state_q == HOLD);
  assign bus.res_class = idx_q;
  assign bus.res_score = max_q;
  assign bus.ovf_err   = ovf_q;
  assign dbg_state_o   = state_q;
`ifdef FC_ARGMAX_SCORES_EN
  assign scores_lin    = scores_q;
`endif
endmodule
